// File: rtl/cpu_pkg.sv
// Shared CPU constants and writeback request bundle used by the
// register-file writeback arbiter.
package cpu_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one search over a valid mask,
// starting at index start and wrapping modulo N.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0] mask,
    input  logic [1:0]   start,
    output logic [1:0]   idx,
    output logic         found
);

    int j;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (mask[j]) begin
                idx   = 2'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Optional decode forwarding ports are enabled by WB_BYPASS_EN.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [1:0]        grant_idx,
    output logic              busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]     byp_addr_a,
    input  logic [AW-1:0]     byp_addr_b,
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [DW-1:0]     byp_data
`endif
);

    logic [1:0]       rr;
    logic [N_REQ-1:0] zero_mask;
    logic [N_REQ-1:0] nz_mask;
    logic [1:0]       pick_idx;
    logic             found;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    // r0 writes are swallowed here and never reach the picker.
    always_comb begin
        zero_mask = '0;
        nz_mask   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_addr[i*AW +: AW] == AW'(REG_ZERO)) begin
                zero_mask[i] = req_valid[i];
            end else begin
                nz_mask[i] = req_valid[i] & ~hold;
            end
        end
    end

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .mask  (nz_mask),
        .start (rr),
        .idx   (pick_idx),
        .found (found)
    );

    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == 2'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
        if (rst_n) begin
            req_ready = zero_mask;
            for (int i = 0; i < N_REQ; i++) begin
                if (found && pick_idx == 2'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
            if (found) begin
                grant_idx = pick_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rr       <= '0;
        end else begin
            rf_we <= found;
            if (found) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                if (int'(pick_idx) == N_REQ - 1) begin
                    rr <= '0;
                end else begin
                    rr <= pick_idx + 2'd1;
                end
            end
        end
    end

    assign busy = rf_we | (|req_valid);

`ifdef WB_BYPASS_EN
    assign byp_hit_a = rf_we & (rf_waddr == byp_addr_a)
                     & (byp_addr_a != AW'(REG_ZERO));
    assign byp_hit_b = rf_we & (rf_waddr == byp_addr_b)
                     & (byp_addr_b != AW'(REG_ZERO));
    assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter (N_REQ=2).
// Bypass checks are compiled in when WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_idx;
    logic        busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_addr_a;
    logic [4:0]  byp_addr_b;
    logic        byp_hit_a;
    logic        byp_hit_b;
    logic [31:0] byp_data;
`endif

    int n_chk;
    int n_fail;
    int n0;
    int n1;
    int n_we;
    logic [4:0]  exp_a;
    logic [31:0] rf_model [32];

    regfile_wb_arbiter #(
        .N_REQ (2),
        .AW    (5),
        .DW    (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr_a (byp_addr_a),
        .byp_addr_b (byp_addr_b),
        .byp_hit_a  (byp_hit_a),
        .byp_hit_b  (byp_hit_b),
        .byp_data   (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_model[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        hold   = 1'b0;
`ifdef WB_BYPASS_EN
        byp_addr_a = '0;
        byp_addr_b = '0;
`endif
        drive(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);

        // reset held two cycles with both requesters valid
        tick(); #1;
        check("rst_ready0", req_ready, 2'b00);
        check("rst_we0", rf_we, 0);
        check("rst_gidx", grant_idx, 0);
        tick(); #1;
        check("rst_ready1", req_ready, 2'b00);
        check("rst_we1", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        tick(); rst_n = 1'b1; #1;
        check("rel_ready", req_ready, 2'b01);
        check("rel_gidx", grant_idx, 0);
        check("rel_we", rf_we, 0);

        tick(); drive(2'b10, 5'd0, 0, 5'd2, 32'h22); #1;
        check("rel_wr_we", rf_we, 1);
        check("rel_wr_addr", rf_waddr, 5'd1);
        check("mem_ready", req_ready, 2'b10);

        // same-address contention, rr back at 0
        tick();
        drive(2'b11, 5'd3, 32'hAAAA_0001, 5'd3, 32'hBBBB_0002);
        #1;
        check("con1_ready", req_ready, 2'b01);
        check("con1_gidx", grant_idx, 0);
        check("con1_waddr", rf_waddr, 5'd2);
        tick(); #1;
        check("con2_ready", req_ready, 2'b10);
        check("con2_gidx", grant_idx, 1);
        check("con2_we", rf_we, 1);
        check("con2_waddr", rf_waddr, 5'd3);
        check("con2_wdata", rf_wdata, 32'hAAAA_0001);
        tick(); drive(2'b00, 0, 0, 0, 0); #1;
        check("con3_we", rf_we, 1);
        check("con3_wdata", rf_wdata, 32'hBBBB_0002);
        tick(); #1;
        check("con_idle_we", rf_we, 0);
        check("con_r3", rf_model[3], 32'hBBBB_0002);
        check("idle_busy", busy, 0);

        // r0 discard alongside a real write
        drive(2'b11, 5'd0, 32'hDEAD_BEEF, 5'd5, 32'h55);
        #1;
        check("z_ready", req_ready, 2'b11);
        check("z_gidx", grant_idx, 1);
        tick(); drive(2'b11, 5'd0, 32'h1, 5'd0, 32'h2); #1;
        check("z_we", rf_we, 1);
        check("z_waddr", rf_waddr, 5'd5);
        check("z_wdata", rf_wdata, 32'h55);
        check("zz_ready", req_ready, 2'b11);
        tick(); drive(2'b11, 5'd1, 32'h11, 5'd2, 32'h22); #1;
        check("zz_we", rf_we, 0);
        check("zz_rr_ready", req_ready, 2'b01);

        // hold: write accepted before hold still retires
        tick(); drive(2'b01, 5'd4, 32'h44, 5'd0, 0); #1;
        check("pre_hold_ready", req_ready, 2'b01);
        tick(); hold = 1'b1;
        drive(2'b01, 5'd7, 32'h77, 5'd0, 0); #1;
        check("h1_ready", req_ready, 2'b00);
        check("h1_we", rf_we, 1);
        check("h1_waddr", rf_waddr, 5'd4);
        check("h1_busy", busy, 1);
        tick(); drive(2'b11, 5'd7, 32'h77, 5'd0, 32'h99); #1;
        check("h2_ready", req_ready, 2'b10);
        check("h2_we", rf_we, 0);
        tick(); drive(2'b01, 5'd7, 32'h77, 5'd0, 0); #1;
        check("h3_ready", req_ready, 2'b00);
        check("h3_we", rf_we, 0);
        tick(); hold = 1'b0; #1;
        check("hrel_ready", req_ready, 2'b01);
        check("hrel_we", rf_we, 0);
        tick(); drive(2'b10, 5'd0, 0, 5'd2, 32'h22); #1;
        check("hwr_we", rf_we, 1);
        check("hwr_waddr", rf_waddr, 5'd7);
        check("hwr_wdata", rf_wdata, 32'h77);
        check("hwr_ready", req_ready, 2'b10);

        // fairness: eight cycles of continuous contention
        n0   = 0;
        n1   = 0;
        n_we = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            drive(2'b11, 5'd10, 32'h100 + k, 5'd11, 32'h200 + k);
            #1;
            check("f_gidx", grant_idx, k % 2);
            check("f_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
            check("f_we", rf_we, 1);
            exp_a = (k == 0) ? 5'd2 : ((k % 2) ? 5'd10 : 5'd11);
            check("f_waddr", rf_waddr, exp_a);
            if (k > 0 && rf_we) n_we++;
            if (grant_idx == 2'd0 && req_ready == 2'b01) n0++;
            if (grant_idx == 2'd1 && req_ready == 2'b10) n1++;
        end
        tick(); drive(2'b00, 0, 0, 0, 0); #1;
        if (rf_we) n_we++;
        check("f_last_waddr", rf_waddr, 5'd11);
        check("f_last_wdata", rf_wdata, 32'h207);
        check("f_n0", n0, 4);
        check("f_n1", n1, 4);
        check("f_pulses", n_we, 8);
        tick(); #1;
        check("f_end_we", rf_we, 0);
        check("f_end_busy", busy, 0);

        // reset drops a pending write and clears rr
        drive(2'b01, 5'd12, 32'hC, 5'd0, 0); #1;
        check("mr_ready", req_ready, 2'b01);
        tick(); drive(2'b00, 0, 0, 0, 0); rst_n = 1'b0; #1;
        check("mr_pend_we", rf_we, 1);
        check("mr_pend_addr", rf_waddr, 5'd12);
        tick(); rst_n = 1'b1;
        drive(2'b11, 5'd13, 32'hD, 5'd14, 32'hE); #1;
        check("mr_drop_we", rf_we, 0);
        check("mr_rr_ready", req_ready, 2'b01);
        tick(); drive(2'b00, 0, 0, 0, 0); #1;
        check("mr_post_addr", rf_waddr, 5'd13);

`ifdef WB_BYPASS_EN
        tick(); drive(2'b01, 5'd9, 32'h1234_5678, 5'd0, 0);
        byp_addr_a = 5'd9;
        byp_addr_b = 5'd0;
        #1;
        check("b_ready", req_ready, 2'b01);
        tick(); drive(2'b00, 0, 0, 0, 0); #1;
        check("b_hit_a", byp_hit_a, 1);
        check("b_hit_b", byp_hit_b, 0);
        check("b_data", byp_data, 32'h1234_5678);
        tick(); #1;
        check("b_hit_a_off", byp_hit_a, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
